// File: rtl/md_issue_ctrl.sv
// Initiator side of the MDU Start/Busy handshake between decode and execute.
// Issues a one-cycle start, tracks the expected latency and stalls HI/LO users in D.
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic [31:0] instr_e,
    input  logic        valid_e,
    input  logic        flush,
    input  logic        busy_i,
    output logic        start,
    output logic        stall_d,
    output logic        md_running,
    output logic        lat_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             first_run;
    logic             unused_bits;

    // mult/multu/div/divu occupy funct 0x18..0x1B
    function automatic logic is_md_start(input logic [5:0] op, input logic [5:0] funct);
        return (op == 6'd0) && (funct[5:2] == 4'b0110);
    endfunction

    // mfhi/mthi/mflo/mtlo occupy funct 0x10..0x13
    function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] funct);
        return (op == 6'd0) && ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));
    endfunction

    assign unused_bits = ^{instr_d[25:6], instr_e[25:6]};

    assign start = valid_e & ~flush & is_md_start(instr_e[31:26], instr_e[5:0])
                 & (state == IDLE) & ~busy_i;

    assign stall_d = is_hilo(instr_d[31:26], instr_d[5:0])
                   & ((state == RUN) | start | busy_i);

    assign md_running = (state == RUN);

    // The counter only decrements, so its load value identifies the first RUN cycle
    assign first_run = is_div ? (cnt == CNT_W'(DIV_LAT)) : (cnt == CNT_W'(MUL_LAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            lat_err   <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            if (stall_d) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        is_div <= instr_e[1];
                        cnt    <= instr_e[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                    end
                end
                RUN: begin
                    // Leave only when both our count and the MDU agree the op is done
                    if (cnt == '0) begin
                        if (busy_i) begin
                            lat_err <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (!busy_i && !first_run) begin
                            lat_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural MDU and issue model.
// The model tracks run length as max(latency, busy length)+1 cycles.
module tb_md_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [31:0] I_MULT  = 32'h0000_0018;
    localparam logic [31:0] I_MULTU = 32'h0000_0019;
    localparam logic [31:0] I_DIV   = 32'h0000_001A;
    localparam logic [31:0] I_DIVU  = 32'h0000_001B;
    localparam logic [31:0] I_MFHI  = 32'h0000_0010;
    localparam logic [31:0] I_MTHI  = 32'h0000_0011;
    localparam logic [31:0] I_MFLO  = 32'h0000_0012;
    localparam logic [31:0] I_MTLO  = 32'h0000_0013;
    localparam logic [31:0] I_ADDU  = 32'h0000_0021;
    localparam logic [31:0] I_LWALS = 32'h8C00_0018;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d;
    logic [31:0] instr_e;
    logic        valid_e;
    logic        flush;
    logic        busy_i;
    logic        start;
    logic        stall_d;
    logic        md_running;
    logic        lat_err;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    int          m_remaining = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_stall_cnt = 32'd0;
    int          busy_left = 0;
    int          busy_len = MUL_LAT;

    bit          e_start, e_stall, e_run, e_err;
    logic [31:0] e_cnt;
    logic        o_start, o_stall, o_run, o_err;
    logic [31:0] o_cnt;

    always #5 clk = ~clk;

    md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_d   (instr_d),
        .instr_e   (instr_e),
        .valid_e   (valid_e),
        .flush     (flush),
        .busy_i    (busy_i),
        .start     (start),
        .stall_d   (stall_d),
        .md_running(md_running),
        .lat_err   (lat_err),
        .stall_cnt (stall_cnt)
    );

    function automatic bit op_md(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (w[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic bit op_hilo(input logic [31:0] w);
        return op_md(w) || ((w[31:26] == 6'd0) && (w[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13}));
    endfunction

    function automatic bit op_div(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (w[5:0] inside {6'h1A, 6'h1B});
    endfunction

    function automatic logic [31:0] pick_instr();
        logic [31:0] w;
        case ($urandom_range(0, 10))
            0:       w = I_MULT;
            1:       w = I_MULTU;
            2:       w = I_DIV;
            3:       w = I_DIVU;
            4:       w = I_MFHI;
            5:       w = I_MTHI;
            6:       w = I_MFLO;
            7:       w = I_MTLO;
            8:       w = I_ADDU;
            9:       w = I_LWALS;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // One clock: drive at negedge, observe 1ns later, advance the model and MDU
    task automatic step(input logic [31:0] d, input logic [31:0] e, input bit v,
                        input bit f, input bit r);
        int lat;
        @(negedge clk);
        instr_d = d;
        instr_e = e;
        valid_e = v;
        flush   = f;
        reset   = r;
        busy_i  = (busy_left > 0);
        #1;
        e_run   = (m_remaining > 0);
        e_start = v && !f && op_md(e) && !e_run && !busy_i;
        e_stall = op_hilo(d) && (e_run || e_start || busy_i);
        e_cnt   = m_stall_cnt;
        e_err   = m_err;
        o_start = start;
        o_stall = stall_d;
        o_run   = md_running;
        o_err   = lat_err;
        o_cnt   = stall_cnt;
        if (r) begin
            m_remaining = 0;
            m_err       = 1'b0;
            m_stall_cnt = 32'd0;
            busy_left   = 0;
        end else begin
            if (e_stall) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e_start) begin
                lat         = op_div(e) ? DIV_LAT : MUL_LAT;
                m_remaining = ((lat > busy_len) ? lat : busy_len) + 1;
                if (busy_len != lat) m_err = 1'b1;
                busy_left   = busy_len;
            end else begin
                if (m_remaining > 0) m_remaining--;
                if (busy_left > 0) busy_left--;
            end
        end
    endtask

    task automatic test_reset();
        step(I_ADDU, I_ADDU, 0, 0, 1);
        step(I_ADDU, I_ADDU, 0, 0, 1);
        step(I_MFHI, I_ADDU, 0, 0, 0);
        checks++;
        if (o_start !== 1'b0 || o_stall !== 1'b0 || o_run !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: start=%b stall=%b run=%b err=%b, want all 0",
                     o_start, o_stall, o_run, o_err);
        end
        checks++;
        if (o_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_cnt: got %0d want 0", o_cnt);
        end
    endtask

    task automatic test_mult();
        int starts = 0;
        int runs = 0;
        busy_len = MUL_LAT;
        step(I_ADDU, I_MULT, 1, 0, 0);
        if (o_start === 1'b1) starts++;
        for (int i = 0; i < 10; i++) begin
            step(I_ADDU, I_ADDU, 0, 0, 0);
            if (o_start === 1'b1) starts++;
            if (o_run === 1'b1) runs++;
            checks++;
            if (o_run !== e_run) begin
                errors++;
                $display("[TB] FAIL mult_running cycle %0d: got %b want %b", i, o_run, e_run);
            end
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("[TB] FAIL mult_start_pulses: got %0d want 1", starts);
        end
        checks++;
        if (runs != MUL_LAT + 1) begin
            errors++;
            $display("[TB] FAIL mult_run_cycles: got %0d want %0d", runs, MUL_LAT + 1);
        end
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mult_lat_err: got %b want 0", o_err);
        end
    endtask

    // The dependent mflo reaches D the cycle after the div issues
    task automatic test_div_stall();
        int stalls = 0;
        bit dropped = 1'b0;
        bit gap = 1'b0;
        logic [31:0] base;
        busy_len = DIV_LAT;
        step(I_ADDU, I_DIV, 1, 0, 0);
        base = m_stall_cnt;
        for (int i = 0; i < 15; i++) begin
            step(I_MFLO, I_ADDU, 0, 0, 0);
            if (o_stall === 1'b1) begin
                stalls++;
                if (dropped) gap = 1'b1;
            end else begin
                dropped = 1'b1;
            end
            checks++;
            if (o_stall !== e_stall) begin
                errors++;
                $display("[TB] FAIL div_stall cycle %0d: got %b want %b", i, o_stall, e_stall);
            end
        end
        checks++;
        if (stalls != DIV_LAT + 1 || gap) begin
            errors++;
            $display("[TB] FAIL div_stall_cycles: got %0d (gap=%b) want %0d consecutive",
                     stalls, gap, DIV_LAT + 1);
        end
        step(I_ADDU, I_ADDU, 0, 0, 0);
        checks++;
        if (o_cnt - base !== 32'd11) begin
            errors++;
            $display("[TB] FAIL div_stall_cnt: got %0d want 11", o_cnt - base);
        end
    endtask

    task automatic test_flush();
        busy_len = MUL_LAT;
        step(I_MFHI, I_MULT, 1, 1, 0);
        checks++;
        if (o_start !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_issue: start=%b stall=%b want 0 0", o_start, o_stall);
        end
        step(I_MFHI, I_ADDU, 0, 0, 0);
        checks++;
        if (o_run !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle: run=%b stall=%b want 0 0", o_run, o_stall);
        end
    endtask

    task automatic test_long_busy();
        int runs = 0;
        busy_len = MUL_LAT + 2;
        step(I_ADDU, I_MULTU, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(I_ADDU, I_ADDU, 0, 0, 0);
            if (o_run === 1'b1) runs++;
        end
        checks++;
        if (runs != MUL_LAT + 3) begin
            errors++;
            $display("[TB] FAIL long_busy_run: got %0d want %0d", runs, MUL_LAT + 3);
        end
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL long_busy_err: got %b want 1", o_err);
        end
        busy_len = MUL_LAT;
        step(I_ADDU, I_MULT, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(I_ADDU, I_ADDU, 0, 0, 0);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lat_err_sticky: got %b want 1", o_err);
        end
        step(I_ADDU, I_ADDU, 0, 0, 1);
        step(I_ADDU, I_ADDU, 0, 0, 0);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat_err_reset: got %b want 0", o_err);
        end
    endtask

    task automatic test_reset_in_run();
        int runs = 0;
        busy_len = DIV_LAT;
        step(I_MFHI, I_DIVU, 1, 0, 0);
        step(I_MFHI, I_ADDU, 0, 0, 0);
        step(I_MFHI, I_ADDU, 0, 0, 0);
        step(I_MFHI, I_ADDU, 0, 0, 1);
        checks++;
        if (o_run !== 1'b1 || o_cnt === 32'd0) begin
            errors++;
            $display("[TB] FAIL pre_reset_run: run=%b cnt=%0d want 1 and nonzero", o_run, o_cnt);
        end
        step(I_MFHI, I_ADDU, 0, 0, 0);
        checks++;
        if (o_run !== 1'b0 || o_cnt !== 32'd0 || o_start !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_run: run=%b cnt=%0d start=%b stall=%b want 0 0 0 0",
                     o_run, o_cnt, o_start, o_stall);
        end
        busy_len = MUL_LAT;
        step(I_ADDU, I_MULT, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(I_ADDU, I_ADDU, 0, 0, 0);
            if (o_run === 1'b1) runs++;
        end
        checks++;
        if (runs != MUL_LAT + 1) begin
            errors++;
            $display("[TB] FAIL post_reset_run: got %0d want %0d", runs, MUL_LAT + 1);
        end
    endtask

    task automatic test_wrap();
        busy_len = MUL_LAT;
        step(I_ADDU, I_MULT, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(I_ADDU, I_ADDU, 0, 0, 0);
            checks++;
            if (o_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL addu_stall cycle %0d: got %b want 0", i, o_stall);
            end
        end
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        m_stall_cnt = 32'hFFFF_FFFD;
        step(I_MFLO, I_MULT, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(I_MFLO, I_ADDU, 0, 0, 0);
            checks++;
            if (o_cnt !== e_cnt) begin
                errors++;
                $display("[TB] FAIL wrap_cnt cycle %0d: got %h want %h", i, o_cnt, e_cnt);
            end
        end
        checks++;
        if (o_cnt !== 32'd4) begin
            errors++;
            $display("[TB] FAIL wrap_final: got %h want 00000004", o_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        bit v, f, r;
        for (int i = 0; i < 400; i++) begin
            d = pick_instr();
            e = pick_instr();
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 63) == 0);
            busy_len = $urandom_range(1, 12);
            step(d, e, v, f, r);
            checks++;
            if (o_start !== e_start || o_stall !== e_stall || o_run !== e_run) begin
                errors++;
                $display("[TB] FAIL random_ctrl cycle %0d: start/stall/run=%b%b%b want %b%b%b",
                         i, o_start, o_stall, o_run, e_start, e_stall, e_run);
            end
            checks++;
            if (o_cnt !== e_cnt) begin
                errors++;
                $display("[TB] FAIL random_cnt cycle %0d: got %0d want %0d", i, o_cnt, e_cnt);
            end
            if (!e_run) begin
                checks++;
                if (o_err !== e_err) begin
                    errors++;
                    $display("[TB] FAIL random_err cycle %0d: got %b want %b", i, o_err, e_err);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        instr_d = I_ADDU;
        instr_e = I_ADDU;
        valid_e = 1'b0;
        flush   = 1'b0;
        busy_i  = 1'b0;
        test_reset();
        test_mult();
        test_div_stall();
        test_flush();
        test_long_busy();
        test_reset_in_run();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
